// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding and defaults for the slow-clock monitor
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    localparam int CNT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 2000000;

endpackage

// File: rtl/clock_edge_monitor_sync_edge_detect.sv
// sync_edge_detect: synchronize an async level and produce rise/fall pulses
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic tick_rise,
    output logic tick_fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   s;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~prev;

    // shift the level through the synchronizer, keep last value, register edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            prev      <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], d};
            prev      <= s;
            tick_rise <= rise;
            tick_fall <= ~s & prev;
        end
    end

endmodule

// File: rtl/clock_edge_monitor.sv
// clock_edge_monitor: edge ticks, period measurement and lock/loss tracking of a slow clock
module clock_edge_monitor
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             timeout;
    logic             meas;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .d         (clk_in),
        .rise      (rise),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall)
    );

    assign timeout = cnt == TO_LAST;
    assign meas    = rise && (state == ARMED || state == LOCKED);
    assign locked  = state == LOCKED;
    assign lost    = state == LOST;

    // a rise always wins over a coincident timeout; falls never move the state
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = rise ? ARMED : IDLE;
            ARMED:   state_d = rise ? LOCKED : (timeout ? LOST : ARMED);
            LOCKED:  state_d = (timeout && !rise) ? LOST : LOCKED;
            LOST:    state_d = rise ? ARMED : LOST;
            default: state_d = IDLE;
        endcase
    end

    // interval counter restarts on each rise; period latched only when the interval is trusted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= rise ? '0 : (&cnt ? cnt : cnt + 1'b1);
            period       <= meas ? cnt + 1'b1 : period;
            period_valid <= meas;
        end
    end

endmodule
